encryption_stream_unit: RTL and testbench

Parametrised next-generation XOR encryption stage for the stream cipher path. It takes data words from the data router into an internal FIFO, so arrivals during a hash wait are not dropped. For each word it requests a hash word from the hash generator, XORs the two and emits the result as a registered pulse to the output holder. It adds a bypass mode, a hash-timeout retry and sticky overflow/timeout status.

---
 rtl/encryption_stream_unit.sv | 147 ++++++++++++++
 tb/tb_encryption_stream_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/encryption_stream_unit.sv
// XOR stream-encryption stage: buffers plaintext words in a small FIFO, fetches one hash
// word per plaintext word and emits the XOR (or the raw word in bypass) as a registered pulse.
module encryption_stream_unit #(
    parameter int WIDTH          = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_pulse,
    input  logic             bypass,
    input  logic             hash_gen_ready,
    output logic             request_pulse_out,
    input  logic [WIDTH-1:0] hash_in,
    input  logic             hash_pulse,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_pulse,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow_flag,
    output logic             timeout_flag,
    input  logic             clear_flags,
    output logic [1:0]       state_out
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        AWAIT_HASH = 2'd1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TO_W-1:0]  tcnt;
    logic [TO_W-1:0]  tcnt_next;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] out_word;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop;
    logic             req_next;
    logic             timeout_hit;

    assign head    = mem[rd_ptr];
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = data_in_pulse & ~full;

    // A timed-out word stays at the head; returning to IDLE lets the normal request path retry it.
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        req_next    = 1'b0;
        tcnt_next   = tcnt;
        timeout_hit = 1'b0;
        out_word    = head;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (bypass) begin
                        pop = 1'b1;
                    end else if (hash_gen_ready) begin
                        req_next   = 1'b1;
                        next_state = AWAIT_HASH;
                        tcnt_next  = '0;
                    end
                end
            end
            AWAIT_HASH: begin
                if (hash_pulse) begin
                    pop        = 1'b1;
                    out_word   = head ^ hash_in;
                    next_state = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && tcnt == TO_W'(TO_LAST)) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                    tcnt_next   = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state             <= IDLE;
            tcnt              <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            data_out          <= '0;
            data_out_pulse    <= 1'b0;
            request_pulse_out <= 1'b0;
            overflow_flag     <= 1'b0;
            timeout_flag      <= 1'b0;
        end else begin
            state             <= next_state;
            tcnt              <= tcnt_next;
            data_out_pulse    <= pop;
            request_pulse_out <= req_next;
            if (pop) begin
                data_out <= out_word;
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set events take priority over a same-cycle clear.
            if (data_in_pulse && full) begin
                overflow_flag <= 1'b1;
            end else if (clear_flags) begin
                overflow_flag <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end else if (clear_flags) begin
                timeout_flag <= 1'b0;
            end
        end
    end

    assign fifo_count = count;
    assign state_out  = state;

endmodule

// File: tb/tb_encryption_stream_unit.sv
// Randomised bench for encryption_stream_unit: a queue-based reference model predicts every
// registered output; expected words go to a scoreboard drained by an independent monitor.
module tb_encryption_stream_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             data_in_pulse = 1'b0;
    logic             bypass = 1'b0;
    logic             hash_gen_ready = 1'b0;
    logic             request_pulse_out;
    logic [WIDTH-1:0] hash_in = '0;
    logic             hash_pulse = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_out_pulse;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow_flag;
    logic             timeout_flag;
    logic             clear_flags = 1'b0;
    logic [1:0]       state_out;

    encryption_stream_unit #(
        .WIDTH(WIDTH),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .data_in(data_in),
        .data_in_pulse(data_in_pulse),
        .bypass(bypass),
        .hash_gen_ready(hash_gen_ready),
        .request_pulse_out(request_pulse_out),
        .hash_in(hash_in),
        .hash_pulse(hash_pulse),
        .data_out(data_out),
        .data_out_pulse(data_out_pulse),
        .fifo_count(fifo_count),
        .overflow_flag(overflow_flag),
        .timeout_flag(timeout_flag),
        .clear_flags(clear_flags),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Reference model: queue of buffered words, waiting flag and count of cycles waited.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] sb[$];
    int               m_waiting;
    int               m_waited;
    int               m_req;
    int               m_ovf;
    int               m_to;
    int               m_pulse;
    logic [WIDTH-1:0] m_dout;
    int               vectors = 0;
    int               miscompares = 0;
    bit               done = 1'b0;

    task automatic model_reset();
        m_q.delete();
        sb.delete();
        m_waiting = 0;
        m_waited  = 0;
        m_req     = 0;
        m_ovf     = 0;
        m_to      = 0;
        m_pulse   = 0;
        m_dout    = '0;
    endtask

    task automatic model_step();
        bit               was_full;
        bit               take;
        bit               to_event;
        logic [WIDTH-1:0] word;
        was_full = (m_q.size() == DEPTH);
        take     = 1'b0;
        to_event = 1'b0;
        word     = '0;
        m_req    = 0;
        if (m_waiting == 0) begin
            if (m_q.size() > 0) begin
                if (bypass) begin
                    take = 1'b1;
                    word = m_q[0];
                end else if (hash_gen_ready) begin
                    m_req     = 1;
                    m_waiting = 1;
                    m_waited  = 0;
                end
            end
        end else if (hash_pulse) begin
            take      = 1'b1;
            word      = m_q[0] ^ hash_in;
            m_waiting = 0;
        end else begin
            m_waited++;
            if (m_waited == TO) begin
                to_event  = 1'b1;
                m_waiting = 0;
            end
        end
        if (data_in_pulse && was_full) m_ovf = 1;
        else if (clear_flags) m_ovf = 0;
        if (to_event) m_to = 1;
        else if (clear_flags) m_to = 0;
        m_pulse = take ? 1 : 0;
        if (take) begin
            void'(m_q.pop_front());
            sb.push_back(word);
            m_dout = word;
        end
        if (data_in_pulse && !was_full) m_q.push_back(data_in);
    endtask

    task automatic apply_stimulus(input int p_push, input int p_ready, input int p_hash,
                                  input int p_bypass, input int p_clr);
        data_in        = WIDTH'($urandom);
        data_in_pulse  = ($urandom_range(99) < p_push);
        hash_gen_ready = ($urandom_range(99) < p_ready);
        hash_in        = WIDTH'($urandom);
        hash_pulse     = ($urandom_range(99) < p_hash);
        bypass         = ($urandom_range(99) < p_bypass);
        clear_flags    = ($urandom_range(99) < p_clr);
    endtask

    task automatic run_cycles(input int n, input int p_push, input int p_ready, input int p_hash,
                              input int p_bypass, input int p_clr);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (nrst) model_step();
            #2;
            apply_stimulus(p_push, p_ready, p_hash, p_bypass, p_clr);
        end
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: per-cycle register checks plus scoreboard draining on each output pulse.
    always @(negedge clk) begin
        if (done) begin
            check_output("scoreboard_drained", sb.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end else begin
            check_output("fifo_count", int'(fifo_count), m_q.size());
            check_output("request_pulse_out", int'(request_pulse_out), m_req);
            check_output("state_out", int'(state_out), m_waiting);
            check_output("overflow_flag", int'(overflow_flag), m_ovf);
            check_output("timeout_flag", int'(timeout_flag), m_to);
            check_output("data_out_pulse", int'(data_out_pulse), m_pulse);
            check_output("data_out_held", int'(data_out), int'(m_dout));
            if (data_out_pulse) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_output at %0t: got %0h, expected no pulse",
                             $time, data_out);
                end else begin
                    check_output("scoreboard_data", int'(data_out), int'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        nrst = 1'b1;
        $display("[TB] reset released, starting random phases");
        run_cycles(300, 50, 70, 20, 0, 5);
        run_cycles(40, 90, 0, 0, 0, 0);
        run_cycles(5, 0, 0, 0, 0, 100);
        run_cycles(250, 70, 50, 30, 100, 3);
        run_cycles(300, 40, 100, 2, 0, 5);
        run_cycles(400, 50, 60, 25, 50, 5);
        run_cycles(40, 0, 100, 50, 50, 0);

        // Park two words with a hash request outstanding, then reset mid-wait.
        run_cycles(2, 100, 100, 0, 0, 0);
        run_cycles(2, 0, 100, 0, 0, 0);
        if (m_waiting != 1) $display("[TB] note: model not awaiting hash before reset");
        nrst = 1'b0;
        model_reset();
        data_in_pulse = 1'b0;
        hash_pulse    = 1'b0;
        run_cycles(3, 0, 0, 0, 0, 0);
        data_in_pulse = 1'b0;
        hash_pulse    = 1'b0;
        @(posedge clk);
        #2;
        nrst = 1'b1;
        run_cycles(10, 0, 100, 100, 0, 0);
        run_cycles(200, 50, 70, 20, 30, 5);
        run_cycles(30, 0, 100, 60, 50, 0);

        @(posedge clk);
        if (nrst) model_step();
        #2;
        done = 1'b1;
    end

endmodule
